// File: rtl/gpu_pkg.sv
// Shared widths, default screen geometry and types for the raster pixel source.
package gpu_pkg;

  localparam int unsigned DEF_H_RES = 640;
  localparam int unsigned DEF_V_RES = 480;

  localparam int unsigned PIX_W = 19;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN
  } raster_state_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order address walker: tracks cur_x/cur_y and the linear row base,
// producing y*H_RES + x incrementally and flagging the final pixel.
module raster_addr_gen
  import gpu_pkg::*;
#(
  parameter int unsigned H_RES = DEF_H_RES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y1,
  output logic [PIX_W-1:0] pix_addr,
  output logic             last_pix
);

  localparam logic [PIX_W-1:0] H_STEP = PIX_W'(H_RES);

  logic [X_W-1:0]   cur_x_q, cur_x_d;
  logic [Y_W-1:0]   cur_y_q, cur_y_d;
  logic [PIX_W-1:0] row_base_q, row_base_d;

  // The only multiply happens once at load; rows afterwards just add H_RES.
  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    if (load) begin
      cur_x_d    = x0;
      cur_y_d    = y0;
      row_base_d = PIX_W'(y0) * H_STEP;
    end else if (advance) begin
      if (cur_x_q == x1) begin
        cur_x_d    = x0;
        cur_y_d    = cur_y_q + 1'b1;
        row_base_d = row_base_q + H_STEP;
      end else begin
        cur_x_d = cur_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
    end else begin
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
    end
  end

  assign pix_addr = row_base_q + PIX_W'(cur_x_q);
  assign last_pix = (cur_x_q == x1) && (cur_y_q == y1);

endmodule

// File: rtl/rect_rasterizer.sv
// Rectangle fill pixel source: walks a constant-colour rectangle one pixel per
// clock, then drains and pulses frame_ready/done. RECT_RASTER_CLIP_EN clamps x1/y1.
module rect_rasterizer
  import gpu_pkg::*;
#(
  parameter int unsigned H_RES        = DEF_H_RES,
  parameter int unsigned V_RES        = DEF_V_RES,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y1,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic [7:0]       in_a,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [PIX_W-1:0] pixel_number,
  output logic             pixel_ready,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic [7:0]       a,
  output logic             frame_ready
);

  localparam logic [X_W:0]     H_LIM    = (X_W+1)'(H_RES);
  localparam logic [Y_W:0]     V_LIM    = (Y_W+1)'(V_RES);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(V_RES - 1);
  localparam int unsigned      CNT_W    = $clog2(FLUSH_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES);

  raster_state_t state_q, state_d;

  logic [X_W-1:0]   x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]   y0_q, y0_d, y1_q, y1_d;
  rgba_t            colour_q, colour_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             frame_ready_q, frame_ready_d;
  logic             pixel_ready_q, pixel_ready_d;
  logic [PIX_W-1:0] pixel_number_q, pixel_number_d;
  rgba_t            pix_colour_q, pix_colour_d;

  logic             gen_load, gen_advance;
  logic [PIX_W-1:0] gen_addr;
  logic             gen_last;

  logic [X_W-1:0]   x1_clip;
  logic [Y_W-1:0]   y1_clip;
  logic             rect_empty;
  logic             x0_oob, y0_oob, x1_oob, y1_oob;

  assign x0_oob = {1'b0, x0_q} >= H_LIM;
  assign y0_oob = {1'b0, y0_q} >= V_LIM;
  assign x1_oob = {1'b0, x1_q} >= H_LIM;
  assign y1_oob = {1'b0, y1_q} >= V_LIM;

  always_comb begin
`ifdef RECT_RASTER_CLIP_EN
    x1_clip    = x1_oob ? X_MAX : x1_q;
    y1_clip    = y1_oob ? Y_MAX : y1_q;
    rect_empty = x0_oob || y0_oob || (x0_q > x1_clip) || (y0_q > y1_clip);
`else
    x1_clip    = x1_q;
    y1_clip    = y1_q;
    rect_empty = x0_oob || y0_oob || x1_oob || y1_oob ||
                 (x0_q > x1_q) || (y0_q > y1_q);
`endif
  end

  raster_addr_gen #(
    .H_RES (H_RES)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (gen_load),
    .advance  (gen_advance),
    .x0       (x0_q),
    .y0       (y0_q),
    .x1       (x1_q),
    .y1       (y1_q),
    .pix_addr (gen_addr),
    .last_pix (gen_last)
  );

  always_comb begin
    state_d        = state_q;
    x0_d           = x0_q;
    y0_d           = y0_q;
    x1_d           = x1_q;
    y1_d           = y1_q;
    colour_d       = colour_q;
    drain_cnt_d    = drain_cnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    frame_ready_d  = 1'b0;
    pixel_ready_d  = 1'b0;
    pixel_number_d = pixel_number_q;
    pix_colour_d   = pix_colour_q;
    gen_load       = 1'b0;
    gen_advance    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x0_d     = x0;
          y0_d     = y0;
          x1_d     = x1;
          y1_d     = y1;
          colour_d = {in_r, in_g, in_b, in_a};
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // Clipped corner replaces the latched one so the walker compares against it.
        gen_load    = 1'b1;
        x1_d        = x1_clip;
        y1_d        = y1_clip;
        drain_cnt_d = '0;
        state_d     = rect_empty ? DRAIN : RUN;
      end
      RUN: begin
        if (!stall) begin
          gen_advance    = 1'b1;
          pixel_ready_d  = 1'b1;
          pixel_number_d = gen_addr;
          pix_colour_d   = colour_q;
          if (gen_last) begin
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == CNT_LAST) begin
          done_d        = 1'b1;
          frame_ready_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      x0_q           <= '0;
      y0_q           <= '0;
      x1_q           <= '0;
      y1_q           <= '0;
      colour_q       <= '0;
      drain_cnt_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      frame_ready_q  <= 1'b0;
      pixel_ready_q  <= 1'b0;
      pixel_number_q <= '0;
      pix_colour_q   <= '0;
    end else begin
      state_q        <= state_d;
      x0_q           <= x0_d;
      y0_q           <= y0_d;
      x1_q           <= x1_d;
      y1_q           <= y1_d;
      colour_q       <= colour_d;
      drain_cnt_q    <= drain_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      frame_ready_q  <= frame_ready_d;
      pixel_ready_q  <= pixel_ready_d;
      pixel_number_q <= pixel_number_d;
      pix_colour_q   <= pix_colour_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign frame_ready  = frame_ready_q;
  assign pixel_ready  = pixel_ready_q;
  assign pixel_number = pixel_number_q;
  assign r            = pix_colour_q.r;
  assign g            = pix_colour_q.g;
  assign b            = pix_colour_q.b;
  assign a            = pix_colour_q.a;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Scoreboard bench for rect_rasterizer: a rectangle model fills an expectation
// queue, a monitor pops and compares on pixel_ready / done.
module tb_rect_rasterizer;

  localparam int H = 640;
  localparam int V = 480;
  localparam int F = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  x0 = '0, x1 = '0;
  logic [8:0]  y0 = '0, y1 = '0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0, in_a = '0;
  logic        busy, done, pixel_ready, frame_ready;
  logic [18:0] pixel_number;
  logic [7:0]  r, g, b, a;

  rect_rasterizer #(
    .H_RES        (H),
    .V_RES        (V),
    .FLUSH_CYCLES (F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .x0           (x0),
    .y0           (y0),
    .x1           (x1),
    .y1           (y1),
    .in_r         (in_r),
    .in_g         (in_g),
    .in_b         (in_b),
    .in_a         (in_a),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .pixel_number (pixel_number),
    .pixel_ready  (pixel_ready),
    .r            (r),
    .g            (g),
    .b            (b),
    .a            (a),
    .frame_ready  (frame_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int unsigned pix;
    logic [31:0] col;
    int          exp_cyc;
    bit          empty;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pix_seen = 0;
  int   dones_seen = 0;
  int   last_pix_cyc = 0;
  bit   ignore_pix = 1'b0;
  bit   rand_stall = 1'b0;
  int   stall_force = 0;

  function automatic void chk(string name, longint act, longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Reference: expected pixel list of a command straight from the fill rules.
  function automatic void model_cmd(int xa, int ya, int xb, int yb,
                                    logic [31:0] col, int scyc, bit chk_lat);
    int   ex1 = xb;
    int   ey1 = yb;
    bit   empty;
    bit   first = 1'b1;
    exp_t e;
`ifdef RECT_RASTER_CLIP_EN
    if (ex1 >= H) ex1 = H - 1;
    if (ey1 >= V) ey1 = V - 1;
    empty = (xa >= H) || (ya >= V) || (xa > ex1) || (ya > ey1);
`else
    empty = (xa >= H) || (ya >= V) || (xb >= H) || (yb >= V) || (xa > xb) || (ya > yb);
`endif
    if (!empty) begin
      for (int yy = ya; yy <= ey1; yy++) begin
        for (int xx = xa; xx <= ex1; xx++) begin
          e.is_done   = 1'b0;
          e.pix       = yy * H + xx;
          e.col       = col;
          e.exp_cyc   = (first && chk_lat) ? scyc + 2 : -1;
          e.empty     = 1'b0;
          e.start_cyc = scyc;
          sb.push_back(e);
          first = 1'b0;
        end
      end
    end
    e.is_done   = 1'b1;
    e.pix       = 0;
    e.col       = '0;
    e.exp_cyc   = -1;
    e.empty     = empty;
    e.start_cyc = scyc;
    sb.push_back(e);
  endfunction

  // Monitor
  initial forever begin
    logic st;
    exp_t e;
    @(posedge clk);
    st = stall;
    cyc++;
    #1;
    if (frame_ready || done) chk("frame_ready_eq_done", frame_ready, done);
    if (pixel_ready && !ignore_pix) begin
      pix_seen++;
      chk("ready_while_stalled", st, 0);
      if (sb.size() == 0 || sb[0].is_done) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pixel: got pixel_number %0d expected no pixel (cycle %0d)",
                 pixel_number, cyc);
      end else begin
        e = sb.pop_front();
        chk("pixel_number", pixel_number, e.pix);
        chk("colour", {r, g, b, a}, e.col);
        if (e.exp_cyc >= 0) chk("first_pixel_cycle", cyc, e.exp_cyc);
        last_pix_cyc = cyc;
      end
    end
    if (done) begin
      dones_seen++;
      chk("busy_at_done", busy, 0);
      if (sb.size() == 0 || !sb[0].is_done) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done: got done with %0d pixels pending expected none (cycle %0d)",
                 sb.size(), cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.empty ? e.start_cyc + F + 2 : last_pix_cyc + F + 1);
      end
    end
  end

  // Stall driver
  initial forever begin
    @(negedge clk);
    if (stall_force > 0) begin
      stall = 1'b1;
      stall_force--;
    end else if (rand_stall) begin
      stall = ($urandom_range(0, 3) == 0);
    end else begin
      stall = 1'b0;
    end
  end

  task automatic run_cmd(input int xa, input int ya, input int xb, input int yb,
                         input logic [31:0] col, input bit chk_lat,
                         input int stall_after, input bit poke);
    int d0, p0, bound, w, h;
    bit ok, forced;
    @(negedge clk);
    x0 = 10'(xa);
    y0 = 9'(ya);
    x1 = 10'(xb);
    y1 = 9'(yb);
    {in_r, in_g, in_b, in_a} = col;
    start = 1'b1;
    model_cmd(xa, ya, xb, yb, col, cyc + 1, chk_lat);
    d0 = dones_seen;
    p0 = pix_seen;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    w = (xb > xa) ? xb - xa + 1 : xa - xb + 1;
    h = (yb > ya) ? yb - ya + 1 : ya - yb + 1;
    bound = 2 * w * h + 40;
    ok = 1'b0;
    forced = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk);
      #2;
      if (poke && i == 5) begin
        x0 = 10'd1; y0 = 9'd1; x1 = 10'd1; y1 = 9'd1;
        start = 1'b1;
      end
      if (poke && i == 6) start = 1'b0;
      if (stall_after > 0 && !forced && pix_seen == p0 + stall_after) begin
        stall_force = 3;
        forced = 1'b1;
      end
      if (dones_seen != d0) ok = 1'b1;
    end
    start = 1'b0;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
      sb.delete();
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int xa, ya, xb, yb, d0;
    #2 reset = 1'b0;
    #1;
    chk("reset_pixel_ready", pixel_ready, 0);
    chk("reset_pixel_number", pixel_number, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_frame_ready", frame_ready, 0);
    chk("reset_rgba", {r, g, b, a}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_cmd(5, 3, 5, 3, 32'h102030FF, 1, 0, 0);
    run_cmd(638, 0, 640, 1, 32'hA1B2C3D4, 1, 0, 0);
    run_cmd(0, 0, 3, 0, 32'h0A0B0C0D, 1, 2, 0);
    run_cmd(9, 0, 4, 0, 32'h11223344, 0, 0, 0);
    run_cmd(10, 470, 12, 480, 32'h55667788, 1, 0, 0);
    run_cmd(600, 470, 639, 479, 32'h99AABBCC, 1, 0, 0);
    run_cmd(0, 0, 639, 9, 32'hDEADBEEF, 1, 0, 1);

    rand_stall = 1'b1;
    for (int n = 0; n < 20; n++) begin
      xa = int'($urandom_range(0, 660));
      ya = int'($urandom_range(0, 490));
      xb = xa + int'($urandom_range(0, 24)) - 3;
      yb = ya + int'($urandom_range(0, 8)) - 2;
      if (xb < 0) xb = 0;
      if (xb > 1023) xb = 1023;
      if (yb < 0) yb = 0;
      if (yb > 511) yb = 511;
      run_cmd(xa, ya, xb, yb, $urandom, 0, 0, 0);
    end
    rand_stall = 1'b0;

    // Abandon a 10x10 fill with reset mid-walk
    @(negedge clk);
    ignore_pix = 1'b1;
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd9; y1 = 9'd9;
    {in_r, in_g, in_b, in_a} = 32'h01020304;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    d0 = dones_seen;
    #2 reset = 1'b0;
    #1;
    chk("midrun_reset_pixel_ready", pixel_ready, 0);
    chk("midrun_reset_pixel_number", pixel_number, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_rgba", {r, g, b, a}, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("no_done_after_reset", dones_seen, d0);
    ignore_pix = 1'b0;
    run_cmd(0, 0, 0, 0, 32'hCAFEF00D, 1, 0, 0);

    repeat (5) @(posedge clk);
    #2;
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
